// File: rtl/fifo_word_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_word_serializer
//  Purpose  : Splits SIZE-bit words taken from a valid/ready slave port into
//             RATIO beats of OUT_W bits on a valid/ready master port, least-
//             significant slice first, with m_last on the final beat. A new
//             word can be taken on the same cycle the last beat of the held
//             word leaves, so back-to-back words stream without a bubble.
//  Ports    : clk, rst      - rising-edge clock, async active-high reset
//             s_valid/s_ready/s_data  - word input handshake and payload
//             m_valid/m_ready/m_data  - beat output handshake and payload
//             m_last        - final beat of the current word
//             busy          - a word is held (mirrors m_valid)
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_word_serializer #(
   parameter int SIZE  = 32,
   parameter int OUT_W = 8,
   parameter int RATIO = SIZE / OUT_W,
   parameter int CNTW  = $clog2(RATIO)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [SIZE-1:0]  s_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [OUT_W-1:0] m_data,
   output logic             m_last,
   output logic             busy
);

   localparam logic [CNTW-1:0] LAST_CNT = CNTW'(RATIO - 1);

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [SIZE-1:0] hold_q,  hold_d;
   logic [CNTW-1:0] cnt_q,   cnt_d;

   logic loaded;
   logic s_hs;
   logic m_hs;

   assign loaded  = (state_q == ST_SHIFT);
   assign m_valid = loaded;
   assign busy    = loaded;
   assign m_last  = loaded && (cnt_q == LAST_CNT);

   // Combinational m_ready -> s_ready path: the slot frees up in the very
   // cycle the last beat is consumed, which is what removes the bubble.
   assign s_ready = !loaded || (m_ready && m_last);

   assign s_hs = s_valid && s_ready;
   assign m_hs = m_valid && m_ready;

   // Beat select as an explicit mux over slice indices.
   always_comb begin
      m_data = '0;
      for (int i = 0; i < RATIO; i++) begin
         if (cnt_q == CNTW'(i)) begin
            m_data = hold_q[i*OUT_W +: OUT_W];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_EMPTY: begin
            if (s_hs) begin
               hold_d  = s_data;
               cnt_d   = '0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (m_hs) begin
               if (!m_last) begin
                  cnt_d = cnt_q + CNTW'(1);
               end else if (s_hs) begin
                  // Reload in place: stay in SHIFT with beat 0 of the new word.
                  hold_d = s_data;
                  cnt_d  = '0;
               end else begin
                  cnt_d   = '0;
                  state_d = ST_EMPTY;
               end
            end
         end
         default: begin
            state_d = ST_EMPTY;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         hold_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fifo_word_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_word_serializer
//  Purpose  : Self-checking bench for fifo_word_serializer (SIZE=32, OUT_W=8).
//             Keeps a queue of expected beats: every accepted word is split
//             into four bytes LSB first; the head of the queue is what the
//             DUT must present.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_word_serializer;

   localparam int SIZE  = 32;
   localparam int OUT_W = 8;
   localparam int RATIO = SIZE / OUT_W;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             s_valid = 1'b0;
   logic             s_ready;
   logic [SIZE-1:0]  s_data = '0;
   logic             m_valid;
   logic             m_ready = 1'b0;
   logic [OUT_W-1:0] m_data;
   logic             m_last;
   logic             busy;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [OUT_W-1:0] data;
      bit               last;
   } beat_t;

   beat_t mq[$];

   fifo_word_serializer #(
      .SIZE  (SIZE),
      .OUT_W (OUT_W)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  (s_data),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .m_last  (m_last),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic bit exp_valid();
      return mq.size() > 0;
   endfunction

   function automatic bit exp_last();
      return (mq.size() > 0) && mq[0].last;
   endfunction

   function automatic logic [OUT_W-1:0] exp_data();
      return (mq.size() > 0) ? mq[0].data : '0;
   endfunction

   function automatic bit exp_s_ready();
      return !exp_valid() || (m_ready && exp_last());
   endfunction

   // Inputs are applied just after a falling edge, then settle.
   task automatic drive(input logic sv, input logic [SIZE-1:0] sd, input logic mr);
      s_valid = sv;
      s_data  = sd;
      m_ready = mr;
      #1;
   endtask

   // Advance one clock; the model consumes/produces at the rising edge.
   task automatic step();
      bit sr;
      @(posedge clk);
      sr = exp_s_ready();
      if (exp_valid() && m_ready) void'(mq.pop_front());
      if (s_valid && sr) begin
         for (int k = 0; k < RATIO; k++) begin
            beat_t b;
            b.data = s_data[k*OUT_W +: OUT_W];
            b.last = (k == RATIO - 1);
            mq.push_back(b);
         end
      end
      @(negedge clk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      mq.delete();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, '0, 1'b0);
         n_checks++;
         if (m_valid !== 1'b0 || m_last !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b1 || m_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_during v=%b l=%b b=%b sr=%b d=%h, need v=0 l=0 b=0 sr=1 d=00",
                     m_valid, m_last, busy, s_ready, m_data);
         end
         @(negedge clk);
      end
      rst = 1'b0;
      drive(1'b0, '0, 1'b0);
      n_checks++;
      if (m_valid !== 1'b0 || m_last !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_after v=%b l=%b b=%b sr=%b, need v=0 l=0 b=0 sr=1",
                  m_valid, m_last, busy, s_ready);
      end
      step();
   endtask

   task automatic test_single_word();
      logic [7:0] exp_b[4] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
      drive(1'b1, 32'hA1B2C3D4, 1'b1);
      step();
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 32'hDEADBEEF, 1'b1);
         n_checks++;
         if (m_valid !== 1'b1 || m_data !== exp_b[i] || m_last !== (i == 3) || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_beat%0d v=%b d=%h l=%b b=%b, need v=1 d=%h l=%b b=1",
                     i, m_valid, m_data, m_last, busy, exp_b[i], (i == 3));
         end
         step();
      end
      drive(1'b0, '0, 1'b1);
      n_checks++;
      if (m_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL single_idle v=%b b=%b, need 0 0", m_valid, busy);
      end
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 32'h03020100, 1'b1);
      step();
      for (int i = 0; i < 8; i++) begin
         drive(i < 4, 32'h07060504, 1'b1);
         n_checks++;
         if (m_valid !== 1'b1 || m_data !== 8'(i) || m_last !== ((i % 4) == 3)) begin
            n_fail++;
            $display("FAIL b2b_beat%0d v=%b d=%h l=%b, need v=1 d=%h l=%b",
                     i, m_valid, m_data, m_last, 8'(i), ((i % 4) == 3));
         end
         if (i < 4) begin
            n_checks++;
            if (s_ready !== (i == 3)) begin
               n_fail++;
               $display("FAIL b2b_sready%0d got %b need %b", i, s_ready, (i == 3));
            end
         end
         step();
      end
      drive(1'b0, '0, 1'b1);
      n_checks++;
      if (m_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_idle m_valid got %b need 0", m_valid);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] rest_b[3] = '{8'hC3, 8'hB2, 8'hA1};
      drive(1'b1, 32'hA1B2C3D4, 1'b1);
      step();
      drive(1'b0, '0, 1'b1);
      step();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, $urandom, 1'b0);
         n_checks++;
         if (m_data !== 8'hC3 || m_valid !== 1'b1 || s_ready !== 1'b0 || m_last !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_stall%0d d=%h v=%b sr=%b l=%b, need d=c3 v=1 sr=0 l=0",
                     i, m_data, m_valid, s_ready, m_last);
         end
         step();
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, '0, 1'b1);
         n_checks++;
         if (m_data !== rest_b[i] || m_valid !== 1'b1 || m_last !== (i == 2)) begin
            n_fail++;
            $display("FAIL bp_resume%0d d=%h v=%b l=%b, need d=%h v=1 l=%b",
                     i, m_data, m_valid, m_last, rest_b[i], (i == 2));
         end
         step();
      end
   endtask

   task automatic test_last_beat_stall();
      logic [7:0] new_b[4] = '{8'h88, 8'h77, 8'h66, 8'h55};
      drive(1'b1, 32'hA1B2C3D4, 1'b1);
      step();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, '0, 1'b1);
         step();
      end
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 32'h55667788, 1'b0);
         n_checks++;
         if (m_last !== 1'b1 || s_ready !== 1'b0 || m_data !== 8'hA1) begin
            n_fail++;
            $display("FAIL lstall%0d l=%b sr=%b d=%h, need l=1 sr=0 d=a1", i, m_last, s_ready, m_data);
         end
         step();
      end
      drive(1'b1, 32'h55667788, 1'b1);
      n_checks++;
      if (s_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL lstall_release s_ready got %b need 1", s_ready);
      end
      step();
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, '0, 1'b1);
         n_checks++;
         if (m_valid !== 1'b1 || m_data !== new_b[i] || m_last !== (i == 3)) begin
            n_fail++;
            $display("FAIL lstall_new%0d v=%b d=%h l=%b, need v=1 d=%h l=%b",
                     i, m_valid, m_data, m_last, new_b[i], (i == 3));
         end
         step();
      end
   endtask

   task automatic test_reset_mid_word();
      logic [7:0] new_b[4] = '{8'h44, 8'h33, 8'h22, 8'h11};
      drive(1'b1, 32'hA1B2C3D4, 1'b1);
      step();
      drive(1'b0, '0, 1'b1);
      step();
      step();
      // Now presenting B2; reset asynchronously between clock edges.
      #1 rst = 1'b1;
      mq.delete();
      #1;
      n_checks++;
      if (m_valid !== 1'b0 || s_ready !== 1'b1 || m_data !== 8'h00 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_immediate v=%b sr=%b d=%h b=%b, need v=0 sr=1 d=00 b=0",
                  m_valid, s_ready, m_data, busy);
      end
      @(negedge clk);
      rst = 1'b0;
      drive(1'b1, 32'h11223344, 1'b1);
      n_checks++;
      if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_after sr=%b v=%b, need sr=1 v=0", s_ready, m_valid);
      end
      step();
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, '0, 1'b1);
         n_checks++;
         if (m_valid !== 1'b1 || m_data !== new_b[i] || m_last !== (i == 3)) begin
            n_fail++;
            $display("FAIL rstmid_beat%0d v=%b d=%h l=%b, need v=1 d=%h l=%b",
                     i, m_valid, m_data, m_last, new_b[i], (i == 3));
         end
         step();
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         drive(($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 3) != 0));
         n_checks++;
         if (m_valid !== exp_valid() || busy !== exp_valid() || m_last !== exp_last() ||
             s_ready !== exp_s_ready() || (exp_valid() && m_data !== exp_data())) begin
            n_fail++;
            $display("FAIL random_c%0d v=%b b=%b l=%b sr=%b d=%h, need v=%b l=%b sr=%b d=%h",
                     c, m_valid, busy, m_last, s_ready, m_data,
                     exp_valid(), exp_last(), exp_s_ready(), exp_data());
         end
         step();
      end
      // Drain whatever is left.
      for (int c = 0; c < RATIO + 1; c++) begin
         drive(1'b0, '0, 1'b1);
         step();
      end
      n_checks++;
      if (m_valid !== 1'b0 || mq.size() != 0) begin
         n_fail++;
         $display("FAIL random_drain v=%b model_left=%0d, need v=0 left=0", m_valid, mq.size());
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_single_word();
      test_back_to_back();
      test_backpressure();
      test_last_beat_stall();
      test_reset_mid_word();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
